// File: rtl/jb_prach_pkg.sv
// Shared types and constants for the PRACH serial-to-parallel demux.
// Optional error counter is enabled by JB_PRACH_S2P_ERR_CNT_EN.
package jb_prach_pkg;

  localparam int JB_PRACH_PRECISION = 16;

  typedef logic [2*JB_PRACH_PRECISION-1:0] prach_sample_t;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/jb_prach_s2p_seq_chk.sv
// Antenna-sequence checker: state machine, expected index, seq_err pulse and
// per-beat store/publish controls. Optional err_cnt under JB_PRACH_S2P_ERR_CNT_EN.
module jb_prach_s2p_seq_chk
  import jb_prach_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int USR_ID_BW  = 2
) (
  input  logic                 clk_4x,
  input  logic                 reset_4x,
  input  logic                 clk_en_i,
  input  logic                 sync_clr_i,
  input  logic                 tvalid_i,
  input  logic [USR_ID_BW-1:0] tuser_i,
  output logic                 store_o,
  output logic [USR_ID_BW-1:0] store_idx_o,
  output logic                 publish_o,
  output logic                 seq_err_o
`ifdef JB_PRACH_S2P_ERR_CNT_EN
  , input  logic                 err_cnt_clr_i
  , output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

  localparam logic [USR_ID_BW-1:0] LAST_IDX = USR_ID_BW'(N_ANTENNAS - 1);

  logic [0:0]           state_q, state_d;
  logic [USR_ID_BW-1:0] exp_q, exp_d;
  logic                 seq_err_q;
  logic                 err_evt;
  logic                 beat;

  assign beat = clk_en_i & tvalid_i & ~sync_clr_i;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    store_o   = 1'b0;
    publish_o = 1'b0;
    err_evt   = 1'b0;
    if (clk_en_i && sync_clr_i) begin
      state_d = ST_IDLE;
      exp_d   = '0;
    end else if (beat) begin
      // In IDLE exp_q is 0, so a match there is exactly "index 0 starts a group".
      if (tuser_i == exp_q) begin
        if (state_q == ST_COLLECT && exp_q == LAST_IDX) begin
          publish_o = 1'b1;
          state_d   = ST_IDLE;
          exp_d     = '0;
        end else begin
          store_o = 1'b1;
          state_d = ST_COLLECT;
          exp_d   = exp_q + USR_ID_BW'(1);
        end
      end else begin
        err_evt = 1'b1;
        if (tuser_i == '0) begin
          store_o = 1'b1;
          state_d = ST_COLLECT;
          exp_d   = USR_ID_BW'(1);
        end else begin
          state_d = ST_IDLE;
          exp_d   = '0;
        end
      end
    end
  end

  // Stores only happen for a matching index or a restart at 0, both equal tuser.
  assign store_idx_o = tuser_i;

  always_ff @(posedge clk_4x) begin
    if (reset_4x) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      seq_err_q <= err_evt;
    end
  end

  assign seq_err_o = seq_err_q;

`ifdef JB_PRACH_S2P_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_4x) begin
    if (reset_4x) begin
      err_cnt_q <= '0;
    end else if (clk_en_i) begin
      if (err_cnt_clr_i)
        err_cnt_q <= '0;
      else if (err_evt && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: rtl/jb_prach_s2p.sv
// PRACH TDM-to-parallel demux: collects one beat per antenna and publishes the
// group on parallel lanes. Optional err_cnt under JB_PRACH_S2P_ERR_CNT_EN.
module jb_prach_s2p
  import jb_prach_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION  = JB_PRACH_PRECISION,
  parameter int USR_ID_BW  = 2
) (
  input  logic                   clk_4x,
  input  logic                   reset_4x,
  input  logic                   clk_en,
  input  logic                   sync_clr,
  input  logic                   tvalid_in,
  input  logic [2*PRECISION-1:0] tdata_in,
  input  logic [USR_ID_BW-1:0]   tuser_in,
  output logic                   tvalid_out,
  output logic [2*PRECISION-1:0] tdata_out [N_ANTENNAS],
  output logic                   seq_err
`ifdef JB_PRACH_S2P_ERR_CNT_EN
  , input  logic                 err_cnt_clr
  , output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic                   store;
  logic [USR_ID_BW-1:0]   store_idx;
  logic                   publish;
  logic                   tvalid_q;
  logic [2*PRECISION-1:0] hold_q  [N_ANTENNAS-1];
  logic [2*PRECISION-1:0] lanes_q [N_ANTENNAS];

  jb_prach_s2p_seq_chk #(
    .N_ANTENNAS (N_ANTENNAS),
    .USR_ID_BW  (USR_ID_BW)
  ) u_seq_chk (
    .clk_4x      (clk_4x),
    .reset_4x    (reset_4x),
    .clk_en_i    (clk_en),
    .sync_clr_i  (sync_clr),
    .tvalid_i    (tvalid_in),
    .tuser_i     (tuser_in),
    .store_o     (store),
    .store_idx_o (store_idx),
    .publish_o   (publish),
    .seq_err_o   (seq_err)
`ifdef JB_PRACH_S2P_ERR_CNT_EN
    , .err_cnt_clr_i (err_cnt_clr)
    , .err_cnt_o     (err_cnt)
`endif
  );

  // The last beat bypasses the hold registers straight onto its lane.
  always_ff @(posedge clk_4x) begin
    if (reset_4x) begin
      tvalid_q <= 1'b0;
      for (int i = 0; i < N_ANTENNAS - 1; i++) hold_q[i] <= '0;
      for (int i = 0; i < N_ANTENNAS; i++)     lanes_q[i] <= '0;
    end else begin
      tvalid_q <= publish;
      for (int i = 0; i < N_ANTENNAS - 1; i++) begin
        if (store && store_idx == USR_ID_BW'(i))
          hold_q[i] <= tdata_in;
      end
      if (publish) begin
        for (int i = 0; i < N_ANTENNAS - 1; i++) lanes_q[i] <= hold_q[i];
        lanes_q[N_ANTENNAS-1] <= tdata_in;
      end
    end
  end

  assign tvalid_out = tvalid_q;
  assign tdata_out  = lanes_q;

endmodule

// File: tb/tb_jb_prach_s2p.sv
// Scoreboard bench for jb_prach_s2p; a group-list reference model predicts
// publishes and seq_err pulses, a negedge monitor pops and compares them.
module tb_jb_prach_s2p;
  import jb_prach_pkg::*;

  localparam int N = 4;

  logic          clk_4x = 1'b0;
  logic          reset_4x;
  logic          clk_en;
  logic          sync_clr;
  logic          tvalid_in;
  prach_sample_t tdata_in;
  logic [1:0]    tuser_in;
  logic          tvalid_out;
  prach_sample_t tdata_out [N];
  logic          seq_err;
`ifdef JB_PRACH_S2P_ERR_CNT_EN
  logic                 err_cnt_clr;
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  jb_prach_s2p #(.N_ANTENNAS(N), .PRECISION(16), .USR_ID_BW(2)) dut (
    .clk_4x     (clk_4x),
    .reset_4x   (reset_4x),
    .clk_en     (clk_en),
    .sync_clr   (sync_clr),
    .tvalid_in  (tvalid_in),
    .tdata_in   (tdata_in),
    .tuser_in   (tuser_in),
    .tvalid_out (tvalid_out),
    .tdata_out  (tdata_out),
    .seq_err    (seq_err)
`ifdef JB_PRACH_S2P_ERR_CNT_EN
    , .err_cnt_clr (err_cnt_clr)
    , .err_cnt     (err_cnt)
`endif
  );

  always #5 clk_4x = ~clk_4x;

  typedef struct {
    bit           is_pub;
    int           cyc;
    logic [127:0] lanes;
  } ev_t;

  ev_t           exp_q[$];
  prach_sample_t grp[$];
  logic [127:0]  last_pub;
  int            ecnt_m;
  int            cyc;
  int            checks;
  int            failures;
  bit            mon_en;

  always @(posedge clk_4x) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [127:0] pack_out();
    logic [127:0] l;
    for (int i = 0; i < N; i++) l[i*32 +: 32] = tdata_out[i];
    return l;
  endfunction

  // One cycle of stimulus; the model predicts what appears after the next edge.
  task automatic step(input bit v, input int idx, input prach_sample_t d,
                      input bit en, input bit clr, input bit eclr = 1'b0);
    ev_t          e;
    logic [127:0] l;
    @(posedge clk_4x); #1;
`ifdef JB_PRACH_S2P_ERR_CNT_EN
    chk(err_cnt == ERR_CNT_W'(ecnt_m), "err_cnt", 128'(err_cnt), 128'(ecnt_m));
    err_cnt_clr = eclr;
`endif
    tvalid_in = v;
    tuser_in  = 2'(idx);
    tdata_in  = d;
    clk_en    = en;
    sync_clr  = clr;
    if (en) begin
      if (clr) begin
        grp.delete();
      end else if (v) begin
        if (idx == grp.size()) begin
          grp.push_back(d);
          if (grp.size() == N) begin
            for (int i = 0; i < N; i++) l[i*32 +: 32] = grp[i];
            e.is_pub = 1'b1; e.cyc = cyc + 1; e.lanes = l;
            exp_q.push_back(e);
            last_pub = l;
            grp.delete();
          end
        end else begin
          e.is_pub = 1'b0; e.cyc = cyc + 1; e.lanes = last_pub;
          exp_q.push_back(e);
          if (ecnt_m < 65535) ecnt_m++;
          grp.delete();
          if (idx == 0) grp.push_back(d);
        end
      end
      if (eclr) ecnt_m = 0;
    end
  endtask

  task automatic beat(input int idx, input prach_sample_t d);
    step(1'b1, idx, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b1, 1'b0);
  endtask

  task automatic group4(input prach_sample_t base);
    for (int i = 0; i < N; i++) beat(i, base + prach_sample_t'(i));
  endtask

  task automatic do_reset();
    idle(2);
    @(posedge clk_4x); #1;
    mon_en   = 1'b0;
    reset_4x = 1'b1;
    tvalid_in = 1'b0;
    @(posedge clk_4x); #1;
    chk(tvalid_out == 1'b0, "rst_tvalid", 128'(tvalid_out), 128'(0));
    chk(seq_err == 1'b0, "rst_seq_err", 128'(seq_err), 128'(0));
    chk(pack_out() == '0, "rst_lanes", pack_out(), 128'(0));
`ifdef JB_PRACH_S2P_ERR_CNT_EN
    chk(err_cnt == '0, "rst_err_cnt", 128'(err_cnt), 128'(0));
`endif
    reset_4x = 1'b0;
    grp.delete();
    exp_q.delete();
    last_pub = '0;
    ecnt_m   = 0;
    mon_en   = 1'b1;
  endtask

  // Monitor: pops on each DUT output event and flags overdue expectations.
  always @(negedge clk_4x) begin
    if (mon_en && !reset_4x) begin
      ev_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk(1'b0, e.is_pub ? "missing_publish" : "missing_seq_err", 128'(0), 128'(e.cyc));
      end
      if (tvalid_out) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_publish", pack_out(), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk(e.is_pub && e.cyc == cyc, "publish_timing", 128'(cyc), 128'(e.cyc));
          chk(pack_out() == e.lanes, "publish_lanes", pack_out(), e.lanes);
        end
      end
      if (seq_err) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_seq_err", 128'(cyc), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk(!e.is_pub && e.cyc == cyc, "seq_err_timing", 128'(cyc), 128'(e.cyc));
          chk(pack_out() == e.lanes, "lanes_hold", pack_out(), e.lanes);
        end
      end
    end
  end

  initial begin
    int r;
    int nx;
    checks = 0; failures = 0; cyc = 0; ecnt_m = 0; last_pub = '0; mon_en = 1'b0;
    reset_4x = 1'b1; clk_en = 1'b1; sync_clr = 1'b0;
    tvalid_in = 1'b0; tdata_in = '0; tuser_in = '0;
`ifdef JB_PRACH_S2P_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk_4x);
    do_reset();

    // Full-rate groups back to back
    beat(0, 32'h11); beat(1, 32'h22); beat(2, 32'h33); beat(3, 32'h44);
    group4(32'hA000_0000);
    idle(2);

    // Gaps and clk_en low mid-group
    beat(0, 32'h11); idle(2); beat(1, 32'h22);
    for (int i = 0; i < 3; i++) step(1'b1, 2, 32'hDEAD, 1'b0, 1'b0);
    idle(2); beat(2, 32'h33); idle(2); beat(3, 32'h44);
    idle(2);

    // Out-of-order then a clean group
    beat(0, 32'h1); beat(1, 32'h2); beat(3, 32'h3); beat(2, 32'h4);
    group4(32'h5555_0000);
    idle(2);

    // Mid-group restart
    beat(0, 32'h10); beat(1, 32'h20); beat(0, 32'h30); beat(1, 32'h40);
    beat(2, 32'h50); beat(3, 32'h60);
    idle(2);

    // Reset mid-group, then a fresh group
    beat(0, 32'h7); beat(1, 32'h8);
    do_reset();
    group4(32'h0B00_0000);
    idle(2);

    // Flush after idx 2 with a beat in the same cycle, then a fresh group
    beat(0, 32'h91); beat(1, 32'h92); beat(2, 32'h93);
    step(1'b1, 3, 32'h94, 1'b1, 1'b1);
    beat(3, 32'h95);
    group4(32'h0C00_0000);
    idle(2);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r  = $urandom_range(0, 99);
      nx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : grp.size();
      step($urandom_range(0, 3) != 0, nx, $urandom, r >= 5, r < 2);
    end
    idle(3);

`ifdef JB_PRACH_S2P_ERR_CNT_EN
    step(1'b0, 0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) beat(2, 32'hBAD);
    idle(1);
    chk(err_cnt == 16'd5, "err_cnt_five", 128'(err_cnt), 128'(5));
    step(1'b1, 3, 32'hBAD, 1'b1, 1'b0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    chk(err_cnt == 16'd0, "err_cnt_clr_wins", 128'(err_cnt), 128'(0));
    for (int i = 0; i < 65540; i++) beat(1, 32'hBAD);
    idle(2);
    chk(err_cnt == 16'hFFFF, "err_cnt_sat", 128'(err_cnt), 128'(16'hFFFF));
`endif

    idle(3);
    chk(exp_q.size() == 0, "scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jb_prach_s2p.md
Name: jb_prach_s2p

Overview:
- Serial-to-parallel demux for the PRACH DFE path. Inverse of the 4x-rate antenna TDM multiplexer.
- Takes one time-multiplexed AXI-stream at clk_4x, tagged per beat with an antenna index on tuser. Rebuilds one complete group of N_ANTENNAS samples and presents it on parallel per-antenna lanes in a single cycle.
- Checks that the antenna sequence is 0,1,..,N_ANTENNAS-1. Flags out-of-order beats and resynchronises on the next index 0.

Parameters:
- N_ANTENNAS, 4, number of antenna lanes; must satisfy 2 <= N_ANTENNAS <= 2**USR_ID_BW.
- PRECISION, 16, bits per I or Q component; a sample is 2*PRECISION bits.
- USR_ID_BW, 2, width of the antenna index on tuser_in.

Ports:
- clk_4x  in  1  single clock, 4x sample rate.
- reset_4x  in  1  synchronous reset, active-high.
- clk_en  in  1  qualifier; when low, no input beat is accepted and no state changes.
- sync_clr  in  1  synchronous flush of any partial group back to IDLE; lanes keep their values.
- tvalid_in  in  1  serial beat valid.
- tdata_in  in  2*PRECISION  serial sample, {Q,I}.
- tuser_in  in  USR_ID_BW  antenna index of the beat.
- tvalid_out  out  1  one-cycle strobe: a complete group is on tdata_out.
- tdata_out  out  2*PRECISION x N_ANTENNAS (unpacked array)  per-antenna samples.
- seq_err  out  1  one-cycle pulse on an out-of-sequence or out-of-range beat.

Behaviour:
- Reset (reset_4x=1 at a clk_4x edge):
  - tvalid_out=0, seq_err=0, every tdata_out lane=0.
  - Holding registers=0, expected index=0, state=IDLE.
  - Reset has priority over every other input.
- A beat is accepted when clk_en=1 && tvalid_in=1. No backpressure exists; every accepted beat is consumed.
- When clk_en=0: tvalid_out and seq_err are forced to 0 and all other state holds.
- Beats may have gaps (tvalid_in low). A group spans any number of cycles.
- States:
  - IDLE: accepted beat with tuser_in==0 → store in hold[0], exp=1, go to COLLECT. Any other accepted beat → seq_err pulse, stay in IDLE, beat dropped.
  - COLLECT, accepted beat with tuser_in==exp and exp<N_ANTENNAS-1 → store in hold[exp], exp++.
  - COLLECT, accepted beat with tuser_in==exp==N_ANTENNAS-1 → publish the group, exp=0, go to IDLE.
  - COLLECT, accepted beat with tuser_in!=exp → seq_err pulse and partial group discarded. If tuser_in==0, it starts a new group (hold[0], exp=1, stay in COLLECT); otherwise go to IDLE and drop the beat.
- Publish: on the cycle after the last beat is accepted (latency 1), all tdata_out lanes update at once to hold[0..N-2] plus the last beat, and tvalid_out=1 for exactly one cycle. tdata_out holds its value until the next publish.
- tuser_in >= N_ANTENNAS is always a mismatch.
- sync_clr=1 (needs clk_en=1) → state=IDLE, exp=0, no seq_err. A beat in the same cycle is ignored. sync_clr has priority over beat acceptance.
- Back-to-back groups at full rate (a beat every cycle) are sustained with no bubble: tvalid_out rises every N_ANTENNAS cycles.

Optional Feature:
- Macro: JB_PRACH_S2P_ERR_CNT_EN.
- With the macro defined:
  - Adds output err_cnt [15:0], a count of seq_err pulses that saturates at 16'hFFFF.
  - Adds input err_cnt_clr [1]. It clears err_cnt synchronously and wins over an increment in the same cycle.
  - Reset value of err_cnt is 0.
- Without the macro: neither port exists and the behaviour is otherwise identical.

Decomposition:
- Shared package jb_prach_pkg:
  - typedef of the sample type (logic [2*PRECISION-1:0]).
  - State enum (IDLE, COLLECT).
  - Saturating-counter width constant for err_cnt.
- Natural sub-module: jb_prach_s2p_seq_chk. It holds the state machine, the expected-index counter and seq_err, and outputs per-beat store/publish/drop controls. The top module keeps the hold and lane registers.

Test Plan:
- Full-rate groups: N=4, beats idx 0,1,2,3 with data 0x11,0x22,0x33,0x44, then a second group. Expect tvalid_out one cycle after idx 3, lanes={0x11,0x22,0x33,0x44}; period 4 cycles; seq_err never asserts.
- Gapped input: the same group with tvalid_in low for 2 cycles between beats, plus clk_en low for 3 cycles mid-group. Expect an identical lane result, one strobe, and no output during clk_en=0.
- Out-of-order: sequence 0,1,3,… Expect seq_err at the beat with idx 3 and no strobe. A following full 0..3 group publishes correctly and lanes keep the prior group until then.
- Mid-group restart: sequence 0,1,0,1,2,3. Expect seq_err at the second 0, then publish of the second group only.
- Reset and flush: reset_4x asserted after idx 1, and in a separate run sync_clr after idx 2. After reset, outputs are 0. Both cases need a fresh 0..3 group to publish; after the flush, no seq_err.
- With JB_PRACH_S2P_ERR_CNT_EN: inject 5 bad beats → err_cnt=5. err_cnt_clr coincident with a bad beat → 0. Preload near saturation → holds at 0xFFFF.
